// File: rtl/dram_write_packer_pkg.sv
// Shared video package for the DRAM write packer.
// Holds the pixel width, the packer FSM states and a word-width helper.
package dram_write_packer_pkg;

    localparam int PIXEL_WIDTH = 16;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        PACK = 2'd1,
        DROP = 2'd2
    } packer_state_t;

    function automatic int word_width(input int dw, input int ppw);
        return dw * ppw;
    endfunction

endpackage

// File: rtl/packer_fifo.sv
// First-word-fall-through FIFO with a registered head output.
// Ports: clk, rst_n, push/din (write), pop (read), full, empty, head.
module packer_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [AW:0]      rptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q[AW-1:0]] <= din;
        end
    end

    // Head tracks the entry at the post-pop read pointer; a word
    // written into that slot this edge bypasses the memory. When
    // nothing is left the head keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            head   <= '0;
        end else begin
            wptr_q <= wptr_q + {{AW{1'b0}}, do_push};
            rptr_q <= rptr_d;
            if (do_push && (rptr_d == wptr_q)) begin
                head <= din;
            end else if (rptr_d != wptr_q) begin
                head <= mem[rptr_d[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/dram_write_packer.sv
// Packs 16-bit pixels into wide DRAM words, buffers them in a small
// FIFO and streams them out; drops and resyncs a frame on overflow.
// Ports: clk, rst_n; pixel in write_valid/write_data/write_last;
// word out word_tvalid/word_tready/word_tdata/word_tlast;
// status overflow (sticky), frame_done (pulse).
// Optional DRAM_WRITE_PACKER_STATS_EN adds dropped_words and
// frames_written counters.
module dram_write_packer
    import dram_write_packer_pkg::*;
#(
    parameter int DATA_WIDTH      = PIXEL_WIDTH,
    parameter int PIXELS_PER_WORD = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  write_valid,
    input  logic [DATA_WIDTH-1:0]                 write_data,
    input  logic                                  write_last,
    output logic                                  word_tvalid,
    input  logic                                  word_tready,
    output logic [DATA_WIDTH*PIXELS_PER_WORD-1:0] word_tdata,
    output logic                                  word_tlast,
    output logic                                  overflow,
    output logic                                  frame_done
`ifdef DRAM_WRITE_PACKER_STATS_EN
    ,
    output logic [15:0]                           dropped_words,
    output logic [15:0]                           frames_written
`endif
);

    localparam int WW = word_width(DATA_WIDTH, PIXELS_PER_WORD);
    localparam int IW = $clog2(PIXELS_PER_WORD);
    localparam logic [IW-1:0] IDX_LAST = IW'(PIXELS_PER_WORD - 1);

    packer_state_t state_q;
    packer_state_t state_d;
    logic [IW-1:0] idx_q;
    logic [WW-1:0] pack_q;
    logic [WW-1:0] word_d;
    logic [WW:0]   head;
    logic          take;
    logic          word_end;
    logic          pop;
    logic          full;
    logic          empty;
    logic          drop;
    logic          fifo_push;
    logic          overflow_q;
    logic          frame_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // A dropped word that carried tlast already ends the frame, so
    // packing can resume immediately instead of waiting in DROP.
    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            (state_q == SYNC),
            (state_q == DROP): begin
                if (write_valid && write_last) state_d = PACK;
            end
            (state_q == PACK): begin
                if (drop && !write_last) state_d = DROP;
            end
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        take = 1'b0;
        unique case (1'b1)
            (state_q == PACK): take = write_valid;
            default:           take = 1'b0;
        endcase
        word_end  = take && ((idx_q == IDX_LAST) || write_last);
        pop       = word_tvalid && word_tready;
        drop      = word_end && full && !pop;
        fifo_push = word_end && !drop;
    end

    // Slots above idx are always zero, so a short final word
    // comes out zero-padded without extra masking.
    always_comb begin
        word_d = pack_q;
        for (int k = 0; k < PIXELS_PER_WORD; k++) begin
            if (k == int'(idx_q)) begin
                word_d[k*DATA_WIDTH +: DATA_WIDTH] = write_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            pack_q <= '0;
        end else if (word_end || (state_q != PACK)) begin
            idx_q  <= '0;
            pack_q <= '0;
        end else if (take) begin
            idx_q  <= idx_q + 1'b1;
            pack_q <= word_d;
        end
    end

    packer_fifo #(
        .WIDTH (WW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   ({write_last, word_d}),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign word_tvalid = !empty;
    assign word_tdata  = head[WW-1:0];
    assign word_tlast  = head[WW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            overflow_q   <= overflow_q | drop;
            frame_done_q <= pop && word_tlast;
        end
    end

    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;

`ifdef DRAM_WRITE_PACKER_STATS_EN
    logic [15:0] dropped_q;
    logic [15:0] frames_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropped_q <= '0;
            frames_q  <= '0;
        end else begin
            if (drop && (dropped_q != 16'hFFFF)) begin
                dropped_q <= dropped_q + 16'd1;
            end
            if (pop && word_tlast) begin
                frames_q <= frames_q + 16'd1;
            end
        end
    end

    assign dropped_words  = dropped_q;
    assign frames_written = frames_q;
`endif

endmodule
